// File: rtl/deal_sched_if.sv
// Card-dealing handshake bundle between the two card requesters and the
// dealing controller. The master side offers cards; the slave side is the
// controller, which grants, forwards and reports.
interface deal_sched_if;
   logic       req1;
   logic [3:0] card1;
   logic       req2;
   logic [3:0] card2;
   logic       gnt1;
   logic       gnt2;
   logic       in_valid1;
   logic [3:0] user1;
   logic       in_valid2;
   logic [3:0] user2;
   logic       rpt_valid;
   logic       rpt_user;
   logic       win_valid;
   logic       deck_reset;
   logic       err;
   logic [2:0] round_cnt;

   modport master (
      output req1, card1, req2, card2,
      input  gnt1, gnt2, in_valid1, user1, in_valid2, user2,
      input  rpt_valid, rpt_user, win_valid, deck_reset, err, round_cnt
   );

   modport slave (
      input  req1, card1, req2, card2,
      output gnt1, gnt2, in_valid1, user1, in_valid2, user2,
      output rpt_valid, rpt_user, win_valid, deck_reset, err, round_cnt
   );
endinterface

// File: rtl/deal_sched.sv
// Dealing controller: user1 takes CARDS_PER_USER cards, then user2, then a
// one-cycle WRAP that flags the winner point and counts rounds. Every card is
// checked against a per-rank copy counter so a deck never yields more than
// RANK_COPIES of any rank; the deck reloads every ROUNDS_PER_DECK rounds.
module deal_sched #(
   parameter int CARDS_PER_USER  = 5,
   parameter int ROUNDS_PER_DECK = 5,
   parameter int RANK_COPIES     = 4
) (
   input logic         clk1,
   input logic         rst_n,
   deal_sched_if.slave bus
);

   localparam int NUM_RANKS = 13;

   typedef enum logic [1:0] {U1, U2, WRAP} state_t;

   state_t     state;
   logic [2:0] card_idx;
   logic [2:0] rank_cnt [NUM_RANKS];

   logic       xfer;
   logic [3:0] card;
   logic       legal;
   logic       take;
   logic       last;
   logic       rpt_pt;
   logic       reload;

   // Grants follow the state; held low while reset is asserted so every
   // output reads 0 during reset and gnt1 appears as soon as it is released.
   assign bus.gnt1 = rst_n && (state == U1);
   assign bus.gnt2 = rst_n && (state == U2);

   // Only the granted requester can transfer; the other request is ignored.
   assign xfer   = ((state == U1) && bus.req1) || ((state == U2) && bus.req2);
   assign card   = (state == U2) ? bus.card2 : bus.card1;
   assign take   = xfer && legal;
   assign last   = (card_idx == 3'(CARDS_PER_USER - 1));
   assign rpt_pt = (card_idx == 3'd2) || (card_idx == 3'd3);
   assign reload = (state == WRAP) && (bus.round_cnt == 3'(ROUNDS_PER_DECK - 1));

   // Card is legal only for ranks 1..13 with at least one copy left; ranks
   // 0, 14 and 15 match no counter and therefore come out illegal.
   always_comb begin
      legal = 1'b0;
      for (int r = 0; r < NUM_RANKS; r++)
         if ((card == 4'(r + 1)) && (rank_cnt[r] != 3'd0))
            legal = 1'b1;
   end

   // One copy counter per rank: reload on deck change, decrement on accept.
   for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
      always_ff @(posedge clk1 or negedge rst_n) begin
         if (!rst_n)
            rank_cnt[r] <= 3'(RANK_COPIES);
         else if (reload)
            rank_cnt[r] <= 3'(RANK_COPIES);
         else if (take && (card == 4'(r + 1)))
            rank_cnt[r] <= rank_cnt[r] - 3'd1;
      end
   end

   // Round FSM with registered single-cycle strobes and forwarded cards.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= U1;
         card_idx       <= 3'd0;
         bus.round_cnt  <= 3'd0;
         bus.in_valid1  <= 1'b0;
         bus.user1      <= 4'd0;
         bus.in_valid2  <= 1'b0;
         bus.user2      <= 4'd0;
         bus.rpt_valid  <= 1'b0;
         bus.rpt_user   <= 1'b0;
         bus.win_valid  <= 1'b0;
         bus.deck_reset <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.in_valid1  <= 1'b0;
         bus.user1      <= 4'd0;
         bus.in_valid2  <= 1'b0;
         bus.user2      <= 4'd0;
         bus.rpt_valid  <= 1'b0;
         bus.rpt_user   <= 1'b0;
         bus.win_valid  <= 1'b0;
         bus.deck_reset <= 1'b0;
         bus.err        <= 1'b0;
         case (state)
            U1, U2: begin
               if (xfer) begin
                  if (legal) begin
                     if (state == U1) begin
                        bus.in_valid1 <= 1'b1;
                        bus.user1     <= card;
                     end else begin
                        bus.in_valid2 <= 1'b1;
                        bus.user2     <= card;
                     end
                     bus.rpt_valid <= rpt_pt;
                     bus.rpt_user  <= rpt_pt && (state == U2);
                     card_idx      <= last ? 3'd0 : card_idx + 3'd1;
                     if (last)
                        state <= (state == U1) ? U2 : WRAP;
                  end else begin
                     // Rejected card: no progress, just flag it.
                     bus.err <= 1'b1;
                  end
               end
            end
            WRAP: begin
               bus.win_valid <= 1'b1;
               if (reload) begin
                  bus.round_cnt  <= 3'd0;
                  bus.deck_reset <= 1'b1;
               end else begin
                  bus.round_cnt <= bus.round_cnt + 3'd1;
               end
               state <= U1;
            end
            default: state <= U1;
         endcase
      end
   end

endmodule

// File: tb/tb_deal_sched.sv
// Directed table-driven bench for deal_sched: each row is one clock of
// requests plus the hand-computed outputs expected just after that edge.
module tb_deal_sched;

   logic clk1 = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   deal_sched_if bus();

   deal_sched #(
      .CARDS_PER_USER (5),
      .ROUNDS_PER_DECK(5),
      .RANK_COPIES    (4)
   ) dut (
      .clk1 (clk1),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      string      name;
      bit         rst;
      logic       r1;
      logic [3:0] c1;
      logic       r2;
      logic [3:0] c2;
      logic [19:0] exp;
   } vec_t;

   vec_t tbl[$];

   // {gnt1,gnt2,iv1,user1,iv2,user2,rpt,rpt_user,win,deck_reset,err,round_cnt}
   function automatic logic [19:0] o(bit g1, bit g2, bit iv1, int u1, bit iv2, int u2,
                                     bit rp, bit ru, bit w, bit dr, bit e, int rc);
      return {g1, g2, iv1, 4'(u1), iv2, 4'(u2), rp, ru, w, dr, e, 3'(rc)};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.gnt1, bus.gnt2, bus.in_valid1, bus.user1, bus.in_valid2, bus.user2,
              bus.rpt_valid, bus.rpt_user, bus.win_valid, bus.deck_reset, bus.err,
              bus.round_cnt};
   endfunction

   task automatic add(string nm, bit rs, bit r1, int c1, bit r2, int c2, logic [19:0] e);
      vec_t v;
      v.name = nm; v.rst = rs; v.r1 = r1; v.c1 = 4'(c1); v.r2 = r2; v.c2 = 4'(c2); v.exp = e;
      tbl.push_back(v);
   endtask

   // user1 card while user2 also requests (must be ignored)
   task automatic t1(int c, bit ok, bit rp, bit last, int rc);
      add("u1_card", 0, 1, c, 1, 13,
          o(!(ok && last), ok && last, ok, ok ? c : 0, 0, 0, rp, 0, 0, 0, !ok, rc));
   endtask

   // user2 card while user1 also requests (must be ignored)
   task automatic t2(int c, bit ok, bit rp, bit last, int rc);
      add("u2_card", 0, 1, 1, 1, c,
          o(0, !(ok && last), 0, 0, ok, ok ? c : 0, rp, rp, 0, 0, !ok, rc));
   endtask

   // WRAP cycle with both users requesting: nothing accepted
   task automatic tw(bit dr, int rc);
      add("wrap", 0, 1, 2, 1, 2, o(1, 0, 0, 0, 0, 0, 0, 0, 1, dr, 0, rc));
   endtask

   task automatic chk(string nm, int idx, logic [19:0] got, logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d got %b want %b", nm, idx, got, exp);
      end
   endtask

   initial begin
      bus.req1 = 0; bus.card1 = 0; bus.req2 = 0; bus.card2 = 0;

      add("reset", 1, 0, 0, 0, 0, 20'd0);
      // round 1: user1 2..6, user2 10..6
      t1(2,1,0,0,0); t1(3,1,0,0,0); t1(4,1,1,0,0); t1(5,1,1,0,0); t1(6,1,0,1,0);
      t2(10,1,0,0,0); t2(9,1,0,0,0); t2(8,1,1,0,0); t2(7,1,1,0,0); t2(6,1,0,1,0);
      tw(0,1);
      // round 2: four aces to user1, fifth ace to user2 rejected, rank 0 rejected
      t1(1,1,0,0,1); t1(1,1,0,0,1); t1(1,1,1,0,1); t1(1,1,1,0,1); t1(13,1,0,1,1);
      t2(1,0,0,0,1); t2(2,1,0,0,1); t2(3,1,0,0,1); t2(0,0,0,0,1);
      t2(4,1,1,0,1); t2(5,1,1,0,1); t2(7,1,0,1,1);
      tw(0,2);
      // round 3: illegal ranks, idle cycle, rank 7 exhausted mid-hand
      t1(15,0,0,0,2);
      add("idle", 0, 0, 3, 0, 3, o(1,0,0,0,0,0,0,0,0,0,0,2));
      t1(0,0,0,0,2); t1(14,0,0,0,2);
      t1(7,1,0,0,2); t1(7,1,0,0,2); t1(7,0,0,0,2);
      t1(8,1,1,0,2); t1(8,1,1,0,2); t1(8,1,0,1,2);
      t2(9,1,0,0,2); t2(9,1,0,0,2); t2(9,1,1,0,2); t2(10,1,1,0,2); t2(11,1,0,1,2);
      tw(0,3);
      // round 4
      t1(11,1,0,0,3); t1(11,1,0,0,3); t1(11,1,1,0,3); t1(12,1,1,0,3); t1(12,1,0,1,3);
      t2(12,1,0,0,3); t2(12,1,0,0,3); t2(13,1,1,0,3); t2(13,1,1,0,3); t2(6,1,0,1,3);
      tw(0,4);
      // round 5: rank 2 exhausted for user2, then deck reload at wrap
      t1(2,1,0,0,4); t1(2,1,0,0,4); t1(3,1,1,0,4); t1(3,1,1,0,4); t1(4,1,0,1,4);
      t2(2,0,0,0,4);
      t2(4,1,0,0,4); t2(5,1,0,0,4); t2(5,1,1,0,4); t2(6,1,1,0,4); t2(10,1,0,1,4);
      tw(1,0);
      // round 6: aces and rank 2 available again
      t1(1,1,0,0,0); t1(1,1,0,0,0); t1(1,1,1,0,0); t1(1,1,1,0,0); t1(2,1,0,1,0);
      t2(3,1,0,0,0); t2(3,1,0,0,0); t2(3,1,1,0,0);
      // reset mid-round: fresh deck, user1 restarts at its first card
      add("reset_mid", 1, 1, 3, 1, 3, 20'd0);
      t1(3,1,0,0,0); t1(3,1,0,0,0); t1(3,1,1,0,0); t1(3,1,1,0,0); t1(3,0,0,0,0);
      t1(4,1,0,1,0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) begin
            bus.req1 = tbl[i].r1; bus.card1 = tbl[i].c1;
            bus.req2 = tbl[i].r2; bus.card2 = tbl[i].c2;
            rst_n = 1'b0;
            @(posedge clk1); #1;
            chk(tbl[i].name, i, obs(), tbl[i].exp);
            bus.req1 = 0; bus.req2 = 0;
            rst_n = 1'b1;
            #1;
            chk("reset_release", i, {15'd0, bus.gnt1, bus.gnt2, bus.round_cnt},
                {15'd0, 1'b1, 1'b0, 3'd0});
         end else begin
            bus.req1 = tbl[i].r1; bus.card1 = tbl[i].c1;
            bus.req2 = tbl[i].r2; bus.card2 = tbl[i].c2;
            @(posedge clk1); #1;
            chk(tbl[i].name, i, obs(), tbl[i].exp);
         end
      end

      bus.req1 = 0; bus.req2 = 0;
      @(posedge clk1); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/deal_sched.md
Name: deal_sched

Overview:
Single-clock dealing controller in the clk1 domain that sequences card traffic into the blackjack probability datapath. It arbitrates two card requesters in strict round order: user1 takes 5 cards, then user2 takes 5 cards. It forwards accepted cards as in_valid1/user1 and in_valid2/user2. It also enforces deck legality (at most 4 of each rank per deck), issues report and winner strobes, and signals the deck reload every ROUNDS_PER_DECK rounds.

Parameters:
CARDS_PER_USER, 5, cards dealt to each user per round (2..7)
ROUNDS_PER_DECK, 5, rounds per deck before deck_reset
RANK_COPIES, 4, copies of each rank 1..13 per deck

Ports:
clk1  input  1  clock
rst_n  input  1  asynchronous active-low reset
req1  input  1  user1 offers a card
card1  input  4  user1 card rank (1..13 legal)
req2  input  1  user2 offers a card
card2  input  4  user2 card rank
gnt1  output  1  user1 may transfer this cycle
gnt2  output  1  user2 may transfer this cycle
in_valid1  output  1  registered: forwarded user1 card valid
user1  output  4  registered: forwarded user1 card, 0 when not valid
in_valid2  output  1  registered: forwarded user2 card valid
user2  output  4  registered: forwarded user2 card, 0 when not valid
rpt_valid  output  1  registered pulse: probability report point
rpt_user  output  1  0 = user1, 1 = user2; valid with rpt_valid
win_valid  output  1  registered pulse: round complete, winner may be computed
deck_reset  output  1  registered pulse: deck reload
err  output  1  registered pulse: illegal or exhausted card rejected
round_cnt  output  3  rounds completed in current deck

Behaviour:
- Reset (async, rst_n=0): state=U1, card_idx=0, round_cnt=0, all rank counters=RANK_COPIES. All outputs are 0, except that gnt1 is 1 once reset is released.
- States:
  - U1: gnt1=1, gnt2=0.
  - U2: gnt1=0, gnt2=1.
  - WRAP: gnt1=0, gnt2=0, lasts exactly 1 cycle.
- Transfer: occurs on a rising edge with reqX=1 and gntX=1. Requests to a non-granted user are ignored; no queuing and no err.
- Legality check: on transfer, the card is checked against the rank counter of that card (ranks 1..13 each have a counter, 3 bits wide).
  - Illegal: card is 0, 14 or 15, or the rank counter is 0.
  - Legal: in_valid of the active user=1 and userX=card the next cycle; the rank counter decrements; card_idx increments.
  - Illegal: err=1 the next cycle; nothing is forwarded; card_idx and the counters are unchanged; the state is unchanged.
- Latency: transfer at edge N gives in_valid/err high in cycle N+1, for exactly 1 cycle per transfer. Back-to-back transfers give contiguous in_valid.
- Report strobe: rpt_valid=1 in the same cycle as in_valid of a user's 3rd and 4th legal card. rpt_user is the active user.
- Hand-over: a legal transfer with card_idx=CARDS_PER_USER-1 sets card_idx to 0.
  - From U1: next state U2. gnt1 drops and gnt2 rises at edge N+1.
  - From U2: next state WRAP.
- WRAP cycle:
  - win_valid=1 in the following cycle.
  - If round_cnt==ROUNDS_PER_DECK-1: round_cnt goes to 0, all rank counters reload to RANK_COPIES, and deck_reset=1 in the same cycle as win_valid.
  - Otherwise round_cnt increments.
  - Next state is U1.
- Simultaneous req1 and req2: only the granted user is served.
- No timeouts: the FSM waits in U1/U2 indefinitely.
- Reset mid-round: all progress and rank counts are discarded and the controller restarts at U1 with a full deck.
- Widths: rank counters saturate at 0 (no underflow, by the legality check). round_cnt wraps only via the WRAP rule.

Test Plan:
- Reset then req1 held with cards 2,3,4,5,6 on consecutive cycles → in_valid1 high 5 cycles with user1=2..6, rpt_valid on cards 4 and 5 with rpt_user=0, gnt2=1 at the cycle after the 5th transfer.
- Full round: user1 cards 1,1,1,1,13 and user2 cards 10,9,8,7,6 → 10 forwarded cards, win_valid pulse 1 cycle after WRAP, round_cnt=1, gnt1 back to 1.
- Exhaustion: in round 2, user1 sends 1 (fifth ace in this deck) → err=1, no in_valid1, card_idx unchanged; the next card 2 is accepted normally.
- Illegal ranks 0 and 15 on card1 → err pulse each, no forwarding, rank counters untouched.
- Five complete rounds → deck_reset and win_valid coincide at the end of round 5, round_cnt=0; in round 6 four aces are accepted again.
- rst_n pulsed low after 3 user2 cards → all outputs 0 during reset; after release, gnt1=1, round_cnt=0, and the next user1 card is card index 1.
